// File: rtl/rgb_sequencer_pkg.sv
// Shared types and colour-wheel table for the RGB sequencer.
// Provides state_t, NUM_KEYS, KEY_MASK ({R,G,B} on-masks) and next_key().
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD
    } state_t;

    localparam int NUM_KEYS = 6;

    // Entry k is the {R,G,B} on-mask of key k: R, Y, G, C, B, M.
    localparam logic [NUM_KEYS-1:0][2:0] KEY_MASK = {
        3'b101,
        3'b001,
        3'b011,
        3'b010,
        3'b110,
        3'b100
    };

    function automatic logic [2:0] next_key(input logic [2:0] k);
        return (k == 3'(NUM_KEYS - 1)) ? 3'd0 : k + 3'd1;
    endfunction

endpackage

// File: rtl/rgb_sequencer_if.sv
// Control/duty bundle between the PWM datapath and the RGB sequencer.
// master drives enable/pwm_wrap; slave (the sequencer) drives duties and key_idx.
interface rgb_seq_if #(
    parameter int W = 11
);
    logic         enable;
    logic         pwm_wrap;
    logic [W-1:0] R_value;
    logic [W-1:0] G_value;
    logic [W-1:0] B_value;
    logic [2:0]   key_idx;

    modport master (
        output enable,
        output pwm_wrap,
        input  R_value,
        input  G_value,
        input  B_value,
        input  key_idx
    );

    modport slave (
        input  enable,
        input  pwm_wrap,
        output R_value,
        output G_value,
        output B_value,
        output key_idx
    );
endinterface

// File: rtl/rgb_gamma.sv
// Per-channel gamma: value = floor(level*level / FS), registered.
// Ports: clk, rst (sync, active-high), level in, value out (1 clk later).
module rgb_gamma #(
    parameter int W  = 11,
    parameter int FS = 1199
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] value
);
    localparam logic [2*W-1:0] FS_W = (2*W)'(FS);

    logic [2*W-1:0] sq;
    logic [W-1:0]   value_d;

    assign sq      = level * level;
    // level <= FS, so the quotient never exceeds FS and fits in W bits.
    assign value_d = W'(sq / FS_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= value_d;
        end
    end
endmodule

// File: rtl/rgb_sequencer.sv
// Steps R/G/B duties around a 6-key colour wheel, paced by pwm_wrap pulses.
// Ports: clk, rst (sync, active-high), bus (rgb_seq_if.slave: enable,
// pwm_wrap in; R/G/B_value, key_idx out). Optional macro RGB_SEQ_GAMMA_EN
// adds a squared-response output stage (one extra clk of latency).
module rgb_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_PERIODS = 10,
    parameter int STEP_SIZE    = 8,
    parameter int HOLD_STEPS   = 100
) (
    input logic      clk,
    input logic      rst,
    rgb_seq_if.slave bus
);
    localparam int W  = $clog2(PWM_INTERVAL);
    localparam int FS = PWM_INTERVAL - 1;
    localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [W:0]    STEP_W = (W+1)'(STEP_SIZE);
    localparam logic [W-1:0]  STEP_N = W'(STEP_SIZE);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_PERIODS - 1);

    state_t               state_q, state_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [2:0]           key_q, key_d;
    logic [2:0][W-1:0]    lvl_q, lvl_d;
    logic [2:0][W-1:0]    ramp_lvl;
    logic [2:0]           hit;
    logic                 step_tick;
    logic                 at_tgt;
    logic                 hold_last;

    assign step_tick = bus.pwm_wrap && (pre_q == PRE_LAST);
    assign hold_last = (int'(hold_q) == HOLD_STEPS - 1);
    assign at_tgt    = &hit;

    // Channel index 2=R, 1=G, 0=B, matching the KEY_MASK bit order.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [W-1:0] tgt;
        logic [W:0]   cur;
        logic [W:0]   t1;
        logic [W:0]   up;
        logic [W-1:0] dn;

        assign tgt = KEY_MASK[key_q][c] ? W'(FS) : '0;
        assign cur = {1'b0, lvl_q[c]};
        assign t1  = {1'b0, tgt};
        assign up  = cur + STEP_W;
        // Only selected when the level is more than one step above target.
        assign dn  = lvl_q[c] - STEP_N;

        assign ramp_lvl[c] = (cur < t1)
                           ? ((up >= t1) ? tgt : up[W-1:0])
                           : (((cur - t1) <= STEP_W) ? tgt : dn);
        assign hit[c] = (ramp_lvl[c] == tgt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = RAMP;
                RAMP: begin
                    if (step_tick && at_tgt && HOLD_STEPS > 0) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (step_tick && hold_last) begin
                        state_d = RAMP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pre_d  = pre_q;
        hold_d = hold_q;
        key_d  = key_q;
        lvl_d  = lvl_q;
        if (!bus.enable || state_q == IDLE) begin
            pre_d  = '0;
            hold_d = '0;
            key_d  = '0;
            lvl_d  = '0;
        end else begin
            if (bus.pwm_wrap) begin
                pre_d = step_tick ? '0 : pre_q + 1'b1;
            end
            if (step_tick) begin
                if (state_q == RAMP) begin
                    lvl_d = ramp_lvl;
                    if (at_tgt) begin
                        hold_d = '0;
                        if (HOLD_STEPS == 0) begin
                            key_d = next_key(key_q);
                        end
                    end
                end else if (state_q == HOLD) begin
                    if (hold_last) begin
                        hold_d = '0;
                        key_d  = next_key(key_q);
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            hold_q <= '0;
            key_q  <= '0;
            lvl_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            hold_q <= hold_d;
            key_q  <= key_d;
            lvl_q  <= lvl_d;
        end
    end

    assign bus.key_idx = key_q;

`ifdef RGB_SEQ_GAMMA_EN
    rgb_gamma #(.W(W), .FS(FS)) u_gamma_r (
        .clk   (clk),
        .rst   (rst),
        .level (lvl_q[2]),
        .value (bus.R_value)
    );
    rgb_gamma #(.W(W), .FS(FS)) u_gamma_g (
        .clk   (clk),
        .rst   (rst),
        .level (lvl_q[1]),
        .value (bus.G_value)
    );
    rgb_gamma #(.W(W), .FS(FS)) u_gamma_b (
        .clk   (clk),
        .rst   (rst),
        .level (lvl_q[0]),
        .value (bus.B_value)
    );
`else
    assign bus.R_value = lvl_q[2];
    assign bus.G_value = lvl_q[1];
    assign bus.B_value = lvl_q[0];
`endif

endmodule

// File: tb/tb_rgb_sequencer.sv
// Self-checking bench for rgb_sequencer (PWM_INTERVAL=16, STEP_PERIODS=2,
// STEP_SIZE=4, HOLD_STEPS=1); also covers the RGB_SEQ_GAMMA_EN build.
module tb_rgb_sequencer;
    localparam int PI = 16;
    localparam int SP = 2;
    localparam int SS = 4;
    localparam int HS = 1;
    localparam int FS = PI - 1;

    // Observed {R,G,B,key} nibbles after each change from power-up 0000.
    localparam logic [15:0] SEQ [34] = '{
        16'h4000, 16'h8000, 16'hC000, 16'hF000, 16'hF001,
        16'hF401, 16'hF801, 16'hFC01, 16'hFF01, 16'hFF02,
        16'hBF02, 16'h7F02, 16'h3F02, 16'h0F02, 16'h0F03,
        16'h0F43, 16'h0F83, 16'h0FC3, 16'h0FF3, 16'h0FF4,
        16'h0BF4, 16'h07F4, 16'h03F4, 16'h00F4, 16'h00F5,
        16'h40F5, 16'h80F5, 16'hC0F5, 16'hF0F5, 16'hF0F0,
        16'hF0B0, 16'hF070, 16'hF030, 16'hF000
    };

    // Target levels per key, in R,G,B order.
    localparam int TGT [6][3] = '{
        '{15, 0, 0}, '{15, 15, 0}, '{0, 15, 0},
        '{0, 15, 15}, '{0, 0, 15}, '{15, 0, 15}
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic man = 1'b0;
    logic gen_on = 1'b0;
    logic rec = 1'b0;
    int   gen_cnt = 0;

    int total = 0;
    int bad = 0;

    rgb_seq_if #(.W(4)) bus ();

    assign bus.enable   = en;
    assign bus.pwm_wrap = man | (gen_on && gen_cnt == PI - 1);

    rgb_sequencer #(
        .PWM_INTERVAL (PI),
        .STEP_PERIODS (SP),
        .STEP_SIZE    (SS),
        .HOLD_STEPS   (HS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        gen_cnt <= gen_on ? (gen_cnt + 1) % PI : 0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Model: levels, key, pulse count within a step, holding flag.
    int lv [3] = '{0, 0, 0};
    int gout [3] = '{0, 0, 0};
    int mkey = 0;
    int npul = 0;
    int nhold = 0;
    bit holding = 0;
    bit running = 0;

    function automatic int gam(input int x);
        return (x * x) / FS;
    endfunction

    task automatic m_step();
        bit all;
        int t;
        if (holding) begin
            nhold++;
            if (nhold >= HS) begin
                mkey = (mkey + 1) % 6;
                holding = 0;
            end
        end else begin
            all = 1;
            for (int c = 0; c < 3; c++) begin
                t = TGT[mkey][c];
                if (lv[c] < t) lv[c] = (lv[c] + SS > t) ? t : lv[c] + SS;
                else lv[c] = (lv[c] - SS < t) ? t : lv[c] - SS;
                if (lv[c] != t) all = 0;
            end
            if (all) begin
                if (HS > 0) begin
                    holding = 1;
                    nhold = 0;
                end else begin
                    mkey = (mkey + 1) % 6;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) gout[c] = rst ? 0 : gam(lv[c]);
        if (rst || !en) begin
            lv = '{0, 0, 0};
            mkey = 0;
            npul = 0;
            nhold = 0;
            holding = 0;
            running = 0;
        end else if (!running) begin
            running = 1;
        end else if (bus.pwm_wrap) begin
            npul++;
            if (npul == SP) begin
                npul = 0;
                m_step();
            end
        end
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        int er, eg, eb;
`ifdef RGB_SEQ_GAMMA_EN
        er = gout[0]; eg = gout[1]; eb = gout[2];
`else
        er = lv[0]; eg = lv[1]; eb = lv[2];
`endif
        total++;
        if (int'(bus.R_value) !== er || int'(bus.G_value) !== eg ||
            int'(bus.B_value) !== eb || int'(bus.key_idx) !== mkey) begin
            bad++;
            $display("FAIL cycle t=%0t: got %0d/%0d/%0d k%0d want %0d/%0d/%0d k%0d",
                     $time, bus.R_value, bus.G_value, bus.B_value, bus.key_idx,
                     er, eg, eb, mkey);
        end
    end

    logic [15:0] seen [$];
    logic [15:0] last = 16'h0000;

    always @(negedge clk) begin
        logic [15:0] cur;
        cur = {bus.R_value, bus.G_value, bus.B_value, 1'b0, bus.key_idx};
        if (rec && cur !== last) begin
            seen.push_back(cur);
            last = cur;
        end
    end

    task automatic pulse();
        @(negedge clk) man = 1'b1;
        @(negedge clk) man = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_r"}, int'(bus.R_value), 0);
        chk({nm, "_g"}, int'(bus.G_value), 0);
        chk({nm, "_b"}, int'(bus.B_value), 0);
        chk({nm, "_k"}, int'(bus.key_idx), 0);
    endtask

    initial begin
        // Reset held with enable and a busy pwm_wrap.
        @(negedge clk) begin rst = 1'b1; en = 1'b1; man = 1'b1; end
        @(negedge clk) man = 1'b0;
        @(negedge clk) man = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        en = 1'b0;
        man = 1'b0;
        repeat (3) @(negedge clk);

        // Free-running wheel through key 5 and the wrap back to key 0.
        rec = 1'b1;
        gen_on = 1'b1;
        en = 1'b1;
        repeat (1100) @(negedge clk);
        rec = 1'b0;
`ifndef RGB_SEQ_GAMMA_EN
        chk("seq_len", int'(seen.size() >= 34), 1);
        for (int i = 0; i < 34; i++) begin
            chk($sformatf("seq%0d", i),
                (i < seen.size()) ? int'(seen[i]) : -1, int'(SEQ[i]));
        end
`endif

        // No pwm_wrap for 200 clk: everything frozen at (15,0,0) key 0.
        gen_on = 1'b0;
        repeat (200) @(negedge clk);
        chk("stall_r", int'(bus.R_value), 15);
        chk("stall_g", int'(bus.G_value), 0);
        chk("stall_b", int'(bus.B_value), 0);
        chk("stall_k", int'(bus.key_idx), 0);

        // Abort coinciding with a step_tick, then restart.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin rst = 1'b0; en = 1'b1; end
        @(negedge clk);
        pulse();
        pulse();
`ifndef RGB_SEQ_GAMMA_EN
        chk("pre_abort_r", int'(bus.R_value), 4);
`endif
        pulse();
        @(negedge clk) begin man = 1'b1; en = 1'b0; end
        @(negedge clk) man = 1'b0;
`ifdef RGB_SEQ_GAMMA_EN
        @(negedge clk);
`endif
        chk_zero("abort");
        en = 1'b1;
        @(negedge clk);
        @(negedge clk) man = 1'b1;
        @(negedge clk);
        @(negedge clk) man = 1'b0;
`ifndef RGB_SEQ_GAMMA_EN
        chk("restart_r", int'(bus.R_value), 4);
        chk("restart_g", int'(bus.G_value), 0);
`else
        // Level just became 4; the gamma output follows one clk later.
        chk("gam_lag4", int'(bus.R_value), 0);
        @(negedge clk);
        chk("gam_4", int'(bus.R_value), 1);
        pulse();
        pulse();
        chk("gam_lag8", int'(bus.R_value), 1);
        @(negedge clk);
        chk("gam_8", int'(bus.R_value), 4);
        pulse();
        pulse();
        @(negedge clk);
        chk("gam_12", int'(bus.R_value), 9);
        pulse();
        pulse();
        @(negedge clk);
        chk("gam_15", int'(bus.R_value), 15);
`endif
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
